// File: rtl/ram_pkg.sv
// Shared types and the lane-merge helper for the true-dual-port RAM.
package ram_pkg;

    typedef enum logic [1:0] {
        RDW_WRITE_FIRST = 2'd0,
        RDW_READ_FIRST  = 2'd1,
        RDW_NO_CHANGE   = 2'd2
    } rdw_mode_e;

    localparam int unsigned MERGE_MAX_W  = 256;
    localparam int unsigned MERGE_MAX_NB = 32;
    localparam int unsigned MERGE_IDX_W  = $clog2(MERGE_MAX_W);
    localparam int unsigned MERGE_NB_W   = $clog2(MERGE_MAX_NB);

    // Replace every lane of old_w whose enable is set with the matching lane of new_w.
    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0]  old_w,
        input logic [MERGE_MAX_W-1:0]  new_w,
        input logic [MERGE_MAX_NB-1:0] be,
        input int unsigned             byte_w
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_w;
        for (int unsigned j = 0; j < MERGE_MAX_W; j++) begin
            if (be[MERGE_NB_W'(j / byte_w)]) begin
                res[MERGE_IDX_W'(j)] = new_w[MERGE_IDX_W'(j)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tdp_bram_pipe_outpipe.sv
// Valid/data shift pipeline adding STAGES register stages; data only loads on valid entries.
module tdp_bram_outpipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STAGES     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    if (STAGES == 0) begin : g_pass
        logic unused_clk_rst_c;
        assign unused_clk_rst_c = clk ^ rst;
        assign valid_o          = valid_i;
        assign data_o           = data_i;
    end else begin : g_pipe
        logic [STAGES-1:0]     valid_q;
        logic [DATA_WIDTH-1:0] data_q [STAGES];

        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            if (s == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) begin
                        valid_q[0] <= 1'b0;
                        data_q[0]  <= '0;
                    end else begin
                        valid_q[0] <= valid_i;
                        if (valid_i) data_q[0] <= data_i;
                    end
                end
            end else begin : g_link
                always_ff @(posedge clk) begin
                    if (rst) begin
                        valid_q[s] <= 1'b0;
                        data_q[s]  <= '0;
                    end else begin
                        valid_q[s] <= valid_q[s-1];
                        if (valid_q[s-1]) data_q[s] <= data_q[s-1];
                    end
                end
            end
        end

        assign valid_o = valid_q[STAGES-1];
        assign data_o  = data_q[STAGES-1];
    end

endmodule

// File: rtl/tdp_bram_pipe.sv
// Single-clock true-dual-port RAM: byte lanes, 1..3-cycle read pipeline, per-port valid, collision flag.
// Define TDP_BRAM_BYPASS_EN to forward a same-cycle cross-port write to the reading port.
module tdp_bram_pipe
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned BYTE_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter rdw_mode_e   RDW_MODE     = RDW_WRITE_FIRST
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en_a_i,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_a_i,
    input  logic [ADDR_WIDTH-1:0]            addr_a_i,
    input  logic [DATA_WIDTH-1:0]            din_a_i,
    input  logic                             en_b_i,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_b_i,
    input  logic [ADDR_WIDTH-1:0]            addr_b_i,
    input  logic [DATA_WIDTH-1:0]            din_b_i,
    output logic [DATA_WIDTH-1:0]            dout_a_o,
    output logic                             valid_a_o,
    output logic [DATA_WIDTH-1:0]            dout_b_o,
    output logic                             valid_b_o,
    output logic                             collision_o
);

    localparam int unsigned NBYTES      = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH       = 2 ** ADDR_WIDTH;
    localparam int unsigned PIPE_STAGES = (READ_LATENCY >= 1) ? READ_LATENCY - 1 : 0;
`ifdef TDP_BRAM_BYPASS_EN
    localparam bit XPORT_FWD = 1'b1;
`else
    localparam bit XPORT_FWD = 1'b0;
`endif

    if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
        $error("tdp_bram_pipe: READ_LATENCY must be in 1..3");
    end
    if ((DATA_WIDTH % BYTE_WIDTH) != 0 || DATA_WIDTH > MERGE_MAX_W || NBYTES > MERGE_MAX_NB) begin : g_bad_width
        $error("tdp_bram_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH within merge limits");
    end

    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NBYTES-1:0]     be
    );
        return DATA_WIDTH'(byte_merge(MERGE_MAX_W'(old_w), MERGE_MAX_W'(new_w),
                                      MERGE_MAX_NB'(be), BYTE_WIDTH));
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] old_a_c, old_b_c, new_a_c, new_b_c;
    logic [NBYTES-1:0]     be_a_c, be_b_c;
    logic                  same_addr_c, wr_a_c, wr_b_c;
    logic                  rd_valid_a_d, rd_valid_b_d, collision_d;
    logic [DATA_WIDTH-1:0] rd_data_a_d, rd_data_b_d;
    logic                  rd_valid_a_q, rd_valid_b_q, collision_q;
    logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_b_q;

    // Post-write word at each port's address; A is merged last so it wins shared lanes.
    always_comb begin
        be_a_c      = en_a_i ? we_a_i : '0;
        be_b_c      = en_b_i ? we_b_i : '0;
        wr_a_c      = |be_a_c;
        wr_b_c      = |be_b_c;
        same_addr_c = (addr_a_i == addr_b_i);
        old_a_c     = mem_q[addr_a_i];
        old_b_c     = mem_q[addr_b_i];
        new_a_c     = lane_merge(lane_merge(old_a_c, din_b_i, same_addr_c ? be_b_c : '0),
                                 din_a_i, be_a_c);
        new_b_c     = lane_merge(lane_merge(old_b_c, din_b_i, be_b_c),
                                 din_a_i, same_addr_c ? be_a_c : '0);

        rd_valid_a_d = en_a_i && !(wr_a_c && RDW_MODE == RDW_NO_CHANGE);
        rd_valid_b_d = en_b_i && !(wr_b_c && RDW_MODE == RDW_NO_CHANGE);
        rd_data_a_d  = wr_a_c ? ((RDW_MODE == RDW_READ_FIRST) ? old_a_c : new_a_c)
                              : (XPORT_FWD ? new_a_c : old_a_c);
        rd_data_b_d  = wr_b_c ? ((RDW_MODE == RDW_READ_FIRST) ? old_b_c : new_b_c)
                              : (XPORT_FWD ? new_b_c : old_b_c);
        collision_d  = en_a_i && en_b_i && same_addr_c && (wr_a_c || wr_b_c);
    end

    // Storage is never cleared; writes are blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr_b_c) mem_q[addr_b_i] <= new_b_c;
            if (wr_a_c) mem_q[addr_a_i] <= new_a_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            collision_q  <= 1'b0;
        end else begin
            rd_valid_a_q <= rd_valid_a_d;
            rd_valid_b_q <= rd_valid_b_d;
            if (rd_valid_a_d) rd_data_a_q <= rd_data_a_d;
            if (rd_valid_b_d) rd_data_b_q <= rd_data_b_d;
            collision_q  <= collision_d;
        end
    end

    tdp_bram_outpipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (PIPE_STAGES)
    ) u_pipe_a (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rd_valid_a_q),
        .data_i  (rd_data_a_q),
        .valid_o (valid_a_o),
        .data_o  (dout_a_o)
    );

    tdp_bram_outpipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (PIPE_STAGES)
    ) u_pipe_b (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rd_valid_b_q),
        .data_i  (rd_data_b_q),
        .valid_o (valid_b_o),
        .data_o  (dout_b_o)
    );

    assign collision_o = collision_q;

endmodule
